// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the oversampling UART receiver.
//   state_t    : receiver FSM states
//   parity_t   : parity mode encoding (none / odd / even)
//   parity_bit : expected parity bit for a received data word
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  // Widest supported data word. Narrower words arrive zero-extended.
  localparam int MAX_DATA_WIDTH = 9;

  // Parity bit the transmitter should have sent for the low `width` bits of
  // `data`. Even parity makes the total count of ones even, odd makes it odd.
  function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] data,
                                      input int unsigned               width,
                                      input parity_t                   mode);
    logic ones;
    ones = 1'b0;
    for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
      if (i < width) ones = ones ^ data[i];
    end
    case (mode)
      PAR_EVEN: parity_bit = ones;
      PAR_ODD:  parity_bit = ~ones;
      default:  parity_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// -----------------------------------------------------------------------------
// uart_os_tick_gen
// Oversample tick generator with a runtime divisor. `tick` is high for one
// clock every div+1 clocks (div=0 -> every clock). A new divisor is picked up
// at the next reload. `restart` reloads the counter so the tick phase lines up
// with the start edge of a frame.
// Ports:
//   clk      system clock
//   rst      asynchronous, active-high reset
//   restart  reload the counter now (first tick follows div+1 clocks later)
//   div      tick period minus one, in clk cycles
//   tick     one-clock oversample strobe
// -----------------------------------------------------------------------------
module uart_os_tick_gen #(
  parameter int DIV_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt;

  // NOTE: clocked state is always written with <= so every flop samples the
  // values present before the edge; = here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == '0) begin
      cnt <= div;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/uart_rx_fifo_less_v2.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_less_v2
// Parametrised oversampling UART receiver with a single-word valid/ready
// output register (no FIFO). Configurable data width, parity and stop bits,
// runtime baud divisor, false-start rejection, break handling, and framing,
// parity and overrun reporting.
//
// Optional build macro:
//   UART_RX_MAJORITY_EN  each bit decision is the 2-of-3 majority of the
//                        samples at centre-1, centre and centre+1, taken at
//                        centre+1. Undefined: single sample at the centre.
//
// Ports:
//   i_clk         system clock
//   i_rst         asynchronous, active-high reset
//   i_rx          asynchronous serial line, idle high
//   i_div         oversample tick period minus one, in i_clk cycles
//   o_data        received data word (LSB received first)
//   o_valid       o_data and error flags are valid
//   i_ready       consumer takes the word when o_valid && i_ready
//   o_frame_err   a stop bit was sampled low (qualified by o_valid)
//   o_parity_err  parity mismatch (qualified by o_valid; 0 when PARITY=0)
//   o_overrun     one-cycle pulse: a completed frame was dropped
//   o_busy        receiver FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_fifo_less_v2
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0,
  parameter int DIV_WIDTH  = 11
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx,
  input  logic [DIV_WIDTH-1:0]  i_div,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_frame_err,
  output logic                  o_parity_err,
  output logic                  o_overrun,
  output logic                  o_busy
);

  localparam int TW  = $clog2(OVERSAMPLE + 1);
  localparam int BCW = 4;
  localparam parity_t PAR_MODE = parity_t'(2'(PARITY));

`ifdef UART_RX_MAJORITY_EN
  // The vote needs the centre+1 sample, so every decision lands one tick late.
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif

  // Decision points. After a decision tcnt reloads to LAG, so the sample
  // points of the following bit stay OVERSAMPLE ticks apart.
  localparam logic [TW-1:0]  START_DECIDE = TW'(OVERSAMPLE / 2 - 1 + LAG);
  localparam logic [TW-1:0]  BIT_DECIDE   = TW'(OVERSAMPLE - 1 + LAG);
  localparam logic [TW-1:0]  TCNT_RELOAD  = TW'(LAG);
  localparam logic [BCW-1:0] LAST_DATA    = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0] LAST_STOP    = BCW'(STOP_BITS - 1);

  // ---------------------------------------------------------------------------
  // Input synchroniser. Idles high so reset never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Oversample tick
  // ---------------------------------------------------------------------------
  logic tick;
  logic restart;

  uart_os_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick (
    .clk     (i_clk),
    .rst     (i_rst),
    .restart (restart),
    .div     (i_div),
    .tick    (tick)
  );

  // ---------------------------------------------------------------------------
  // Bit decision value
  // ---------------------------------------------------------------------------
  logic bit_val;

`ifdef UART_RX_MAJORITY_EN
  // hist[0] is the sample from the previous tick (centre), hist[1] the one
  // before (centre-1); rx_s on the decision tick is centre+1.
  logic [1:0] hist;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hist <= 2'b11;
    end else if (tick) begin
      hist <= {hist[0], rx_s};
    end
  end

  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  state_t                state, state_n;
  logic [TW-1:0]         tcnt, tcnt_n;
  logic [BCW-1:0]        bcnt, bcnt_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic                  perr, perr_n;
  logic                  ferr, ferr_n;
  logic                  complete;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      tcnt  <= '0;
      bcnt  <= '0;
      shreg <= '0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      state <= state_n;
      tcnt  <= tcnt_n;
      bcnt  <= bcnt_n;
      shreg <= shreg_n;
      perr  <= perr_n;
      ferr  <= ferr_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch to hold its old value.
    state_n  = state;
    tcnt_n   = tcnt;
    bcnt_n   = bcnt;
    shreg_n  = shreg;
    perr_n   = perr;
    ferr_n   = ferr;
    restart  = 1'b0;
    complete = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_n = ST_START;
          tcnt_n  = '0;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
          restart = 1'b1;
        end
      end

      ST_START: begin
        if (tick) begin
          if (tcnt == START_DECIDE) begin
            if (bit_val) begin
              // Line is high again mid start bit: a glitch, not a frame.
              state_n = ST_IDLE;
            end else begin
              state_n = ST_DATA;
              tcnt_n  = TCNT_RELOAD;
              bcnt_n  = '0;
            end
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (tcnt == BIT_DECIDE) begin
            // LSB arrives first, so shift in from the top.
            shreg_n = {bit_val, shreg[DATA_WIDTH-1:1]};
            tcnt_n  = TCNT_RELOAD;
            if (bcnt == LAST_DATA) begin
              bcnt_n  = '0;
              state_n = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bcnt_n = bcnt + 1'b1;
            end
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
      end

      ST_PARITY: begin
        if (tick) begin
          if (tcnt == BIT_DECIDE) begin
            perr_n  = bit_val != parity_bit(MAX_DATA_WIDTH'(shreg), DATA_WIDTH, PAR_MODE);
            tcnt_n  = TCNT_RELOAD;
            state_n = ST_STOP;
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (tcnt == BIT_DECIDE) begin
            if (!bit_val) ferr_n = 1'b1;
            tcnt_n = TCNT_RELOAD;
            if (bcnt == LAST_STOP) begin
              // Finish at the stop centre so a back-to-back start edge is
              // seen with half a bit of margin.
              complete = 1'b1;
              bcnt_n   = '0;
              state_n  = ferr_n ? ST_BREAK : ST_IDLE;
            end else begin
              bcnt_n = bcnt + 1'b1;
            end
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
      end

      ST_BREAK: begin
        // A low stop bit may be a held break; wait for the line to recover
        // before looking for the next start edge.
        if (rx_s) state_n = ST_IDLE;
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register with valid/ready handshake
  // ---------------------------------------------------------------------------
  logic accept;
  assign accept = o_valid && i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (complete && (!o_valid || accept)) begin
        // Empty slot, or the held word leaves this same cycle.
        o_data       <= shreg;
        o_frame_err  <= ferr_n;
        o_parity_err <= perr_n;
        o_valid      <= 1'b1;
      end else if (complete) begin
        // Consumer is stalled: keep the held word, drop the new one.
        o_overrun <= 1'b1;
      end else if (accept) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_less_v2.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo_less_v2
// Bench for uart_rx_fifo_less_v2. Two instances share the clock, reset and
// divisor: dut_a is 8N1, dut_b is 8E1 (even parity). Expected words are
// queued when a frame is driven and compared when the DUT hands them over.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_fifo_less_v2;

`ifdef UART_RX_MAJORITY_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif
  localparam int DIV_WIDTH = 11;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic [DIV_WIDTH-1:0] div;
  logic                 rx_a, rx_b;
  logic                 ready_a, ready_b;

  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       fe_a, fe_b, pe_a, pe_b;
  logic       ovr_a, ovr_b;
  logic       busy_a, busy_b;

  int   checks;
  int   passed;
  int   fails;
  int   cyc;
  int   rise_a;
  int   ovr_cnt_a, ovr_cnt_b;
  logic vprev_a;
  exp_t q_a[$];
  exp_t q_b[$];

  uart_rx_fifo_less_v2 #(
    .DATA_WIDTH (8), .OVERSAMPLE (16), .STOP_BITS (1), .PARITY (0), .DIV_WIDTH (DIV_WIDTH)
  ) dut_a (
    .i_clk (clk), .i_rst (rst), .i_rx (rx_a), .i_div (div),
    .o_data (data_a), .o_valid (valid_a), .i_ready (ready_a),
    .o_frame_err (fe_a), .o_parity_err (pe_a), .o_overrun (ovr_a), .o_busy (busy_a)
  );

  uart_rx_fifo_less_v2 #(
    .DATA_WIDTH (8), .OVERSAMPLE (16), .STOP_BITS (1), .PARITY (2), .DIV_WIDTH (DIV_WIDTH)
  ) dut_b (
    .i_clk (clk), .i_rst (rst), .i_rx (rx_b), .i_div (div),
    .o_data (data_b), .o_valid (valid_b), .i_ready (ready_b),
    .o_frame_err (fe_b), .o_parity_err (pe_b), .o_overrun (ovr_b), .o_busy (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      vprev_a = 1'b0;
    end else begin
      if (ovr_a) ovr_cnt_a++;
      if (valid_a && !vprev_a) rise_a = cyc;
      vprev_a = valid_a;
      if (valid_a && ready_a) begin
        check("a_word_expected", q_a.size() != 0, 1);
        if (q_a.size() != 0) begin
          exp_t e;
          e = q_a.pop_front();
          check("a_data", data_a, e.data);
          check("a_frame_err", fe_a, e.fe);
          check("a_parity_err", pe_a, e.pe);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (ovr_b) ovr_cnt_b++;
      if (valid_b && ready_b) begin
        check("b_word_expected", q_b.size() != 0, 1);
        if (q_b.size() != 0) begin
          exp_t e;
          e = q_b.pop_front();
          check("b_data", data_b, e.data);
          check("b_frame_err", fe_b, e.fe);
          check("b_parity_err", pe_b, e.pe);
        end
      end
    end
  end

  task automatic set_rx(input bit to_b, input logic v);
    if (to_b) rx_b = v;
    else      rx_a = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame: start, 8 data bits LSB first, optional parity, one
  // stop bit. glitch_bit inverts a 5-clock slice around that bit's centre
  // (bit index 0 = start bit; -1 = no glitch).
  task automatic send(input bit to_b, input logic [7:0] d, input bit with_par,
                      input logic par, input int bc, input int glitch_bit);
    logic lv[$];
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(d[i]);
    if (with_par) lv.push_back(par);
    lv.push_back(1'b1);
    for (int c = 0; c < lv.size() * bc; c++) begin
      logic v;
      v = lv[c / bc];
      if ((c / bc) == glitch_bit && (c % bc) >= bc / 2 - 2 && (c % bc) < bc / 2 + 3) v = ~v;
      @(posedge clk);
      #1;
      set_rx(to_b, v);
    end
  endtask

  initial begin
    int start_cyc;
    int ovr_before;
    checks = 0; passed = 0; fails = 0; cyc = 0;
    rise_a = 0; ovr_cnt_a = 0; ovr_cnt_b = 0; vprev_a = 1'b0;
    rst = 1'b1; div = '0; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    idle(3);
    check("rst_valid", valid_a, 0);
    check("rst_data", data_a, 0);
    check("rst_flags", {fe_a, pe_a, ovr_a, busy_a}, 0);
    check("rst_b_outputs", {valid_b, data_b, fe_b, pe_b, ovr_b, busy_b}, 0);
    rst = 1'b0;
    idle(5);

    // 8N1 0xA5: o_valid one clock after the stop centre, no errors.
    q_a.push_back('{data: 8'hA5, fe: 1'b0, pe: 1'b0});
    start_cyc = cyc + 1;
    send(1'b0, 8'hA5, 1'b0, 1'b0, 16, -1);
    idle(3);
    check("a5_latency", rise_a - start_cyc, 155 + LAG);
    check("a5_consumed", q_a.size(), 0);
    check("a5_no_overrun", ovr_cnt_a, 0);

    // Even parity: wrong parity bit then correct one.
    q_b.push_back('{data: 8'h0F, fe: 1'b0, pe: 1'b1});
    send(1'b1, 8'h0F, 1'b1, 1'b1, 16, -1);
    q_b.push_back('{data: 8'h0F, fe: 1'b0, pe: 1'b0});
    send(1'b1, 8'h0F, 1'b1, 1'b0, 16, -1);
    q_b.push_back('{data: 8'h07, fe: 1'b0, pe: 1'b0});
    send(1'b1, 8'h07, 1'b1, 1'b1, 16, -1);
    idle(4);
    check("par_consumed", q_b.size(), 0);

    // 4-clock glitch: false start, no word.
    rx_a = 1'b0;
    idle(4);
    rx_a = 1'b1;
    idle(2);
    check("glitch_busy_start", busy_a, 1);
    idle(25);
    check("glitch_busy_idle", busy_a, 0);
    check("glitch_no_valid", valid_a, 0);

    // 20-bit break: one all-zero word with frame error, then BREAK until high.
    q_a.push_back('{data: 8'h00, fe: 1'b1, pe: 1'b0});
    rx_a = 1'b0;
    idle(320);
    check("break_word_seen", q_a.size(), 0);
    check("break_busy_low_line", busy_a, 1);
    rx_a = 1'b1;
    idle(5);
    check("break_idle_after_high", busy_a, 0);

    // Stalled consumer: 0x11 held, 0x22 dropped with one overrun pulse.
    ready_a = 1'b0;
    ovr_before = ovr_cnt_a;
    q_a.push_back('{data: 8'h11, fe: 1'b0, pe: 1'b0});
    send(1'b0, 8'h11, 1'b0, 1'b0, 16, -1);
    send(1'b0, 8'h22, 1'b0, 1'b0, 16, -1);
    idle(2);
    check("ovr_held_data", data_a, 8'h11);
    check("ovr_held_valid", valid_a, 1);
    check("ovr_pulses", ovr_cnt_a - ovr_before, 1);
    ready_a = 1'b1;
    idle(2);
    check("ovr_valid_drops", valid_a, 0);
    check("ovr_drained", q_a.size(), 0);

    // Accept the held 0x11 on exactly the cycle 0x33 completes.
    ready_a = 1'b0;
    q_a.push_back('{data: 8'h11, fe: 1'b0, pe: 1'b0});
    send(1'b0, 8'h11, 1'b0, 1'b0, 16, -1);
    idle(2);
    ovr_before = ovr_cnt_a;
    q_a.push_back('{data: 8'h33, fe: 1'b0, pe: 1'b0});
    fork
      send(1'b0, 8'h33, 1'b0, 1'b0, 16, -1);
      begin
        repeat (155 + LAG) @(posedge clk);
        #1 ready_a = 1'b1;
        @(posedge clk);
        #1 ready_a = 1'b0;
      end
    join
    idle(2);
    check("simul_data", data_a, 8'h33);
    check("simul_valid", valid_a, 1);
    check("simul_no_overrun", ovr_cnt_a - ovr_before, 0);
    check("simul_0x11_taken", q_a.size(), 1);
    ready_a = 1'b1;
    idle(2);
    check("simul_drained", q_a.size(), 0);

    // Hold a word, reset mid-DATA, then run at i_div=4 (80 clk/bit).
    ready_a = 1'b0;
    q_a.push_back('{data: 8'h44, fe: 1'b0, pe: 1'b0});
    send(1'b0, 8'h44, 1'b0, 1'b0, 16, -1);
    rx_a = 1'b0;
    idle(64);
    check("mid_data_busy", busy_a, 1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", valid_a, 0);
    check("async_rst_busy", busy_a, 0);
    check("async_rst_data", data_a, 0);
    q_a.delete();
    rx_a = 1'b1;
    idle(3);
    rst = 1'b0;
    div = 11'd4;
    ready_a = 1'b1;
    idle(40);
    check("post_rst_no_word", valid_a, 0);
    q_a.push_back('{data: 8'h5A, fe: 1'b0, pe: 1'b0});
    send(1'b0, 8'h5A, 1'b0, 1'b0, 80, -1);
    idle(4);
    check("div4_received", q_a.size(), 0);

`ifdef UART_RX_MAJORITY_EN
    // One-tick glitch at the centre of data bit 3 is outvoted.
    q_a.push_back('{data: 8'h5A, fe: 1'b0, pe: 1'b0});
    send(1'b0, 8'h5A, 1'b0, 1'b0, 80, 4);
    idle(4);
    check("vote_received", q_a.size(), 0);
`endif

    idle(10);
    check("final_a_empty", q_a.size(), 0);
    check("final_b_empty", q_b.size(), 0);
    check("final_ovr_a", ovr_cnt_a, 1);
    check("final_ovr_b", ovr_cnt_b, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo_less_v2.md
Name: uart_rx_fifo_less_v2

Overview:
Parametrised oversampling UART receiver. It succeeds the fixed 8N1 receiver. It adds:
- configurable data width, parity and stop bits
- a runtime baud divisor
- false-start rejection and break handling
- framing, parity and overrun error reporting
- a valid/ready output handshake

It sits between the pad-side RX pin and the CPU-side peripheral register or bus bridge.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9), LSB first
OVERSAMPLE, 16, ticks per bit (8 or 16)
STOP_BITS, 1, stop bits checked (1 or 2)
PARITY, 0, 0 = none, 1 = odd, 2 = even
DIV_WIDTH, 11, width of the runtime divisor input

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset; asynchronous, active-high
i_rx  in  1  asynchronous serial line, idle high
i_div  in  DIV_WIDTH  oversample tick period minus one, in i_clk cycles
o_data  out  DATA_WIDTH  received data word
o_valid  out  1  o_data and error flags are valid
i_ready  in  1  consumer accepts the word when o_valid && i_ready
o_frame_err  out  1  stop bit sampled low; qualified by o_valid
o_parity_err  out  1  parity mismatch; qualified by o_valid; always 0 when PARITY=0
o_overrun  out  1  one-cycle pulse: a completed frame was dropped
o_busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-high (i_rst). All state is reset asynchronously.
- Reset values: o_valid=0, o_data=0, o_frame_err=0, o_parity_err=0, o_overrun=0, o_busy=0. The synchroniser flops reset to 1.
- Reset mid-frame aborts the frame immediately; no partial word is ever presented.
- Input synchroniser: 2-flop on i_rx. All FSM decisions use the synchronised value rx_s.
- Tick generator: a tick pulses every i_div+1 i_clk cycles, so i_div=0 gives a tick every cycle. A new i_div value takes effect at the next counter reload. The tick counter restarts on the IDLE->START transition so bit timing is phase-aligned to the start edge.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK. tcnt counts ticks within a bit; bcnt counts bits.
  - IDLE: rx_s==0 -> START, tcnt=0.
  - START: on the tick where tcnt==OVERSAMPLE/2-1, sample. If the sample is 1, it is a false start: go to IDLE, produce no output. If 0, go to DATA with tcnt=0 and bcnt=0.
  - DATA: sample on the tick where tcnt==OVERSAMPLE-1 (bit centre) and shift in LSB first. After DATA_WIDTH bits, go to PARITY if PARITY!=0, else STOP.
  - PARITY: sample at the centre and compare against the XOR of the data (odd or even per PARITY).
  - STOP: sample at the centre of each of the STOP_BITS stop bits. Any stop sample of 0 sets the frame error.
  - After the last stop-centre sample: go to IDLE with no error, or to BREAK on a frame error. BREAK waits for rx_s==1, then goes to IDLE.
  - Completion happens at the stop-bit centre, leaving half a bit of margin for back-to-back frames.
- Output register: on completion, o_data, o_frame_err and o_parity_err load and o_valid=1 on the next cycle. They hold until o_valid && i_ready, which clears o_valid on the next cycle.
- Overrun: a completion while o_valid && !i_ready drops the new frame, leaves the held word intact, and pulses o_overrun for 1 cycle.
- Simultaneous completion and acceptance in the same cycle: the new word loads, o_valid stays 1, no overrun.
- DATA_WIDTH=9: o_data bit 8 is the 9th received bit.

Optional Feature:
UART_RX_MAJORITY_EN:
- Defined: each bit decision (start, data, parity, stop) is the 2-of-3 majority of rx_s at tcnt centre-1, centre and centre+1. The decision is taken at centre+1; the next bit's sample points are unchanged.
- Undefined: single sample at the centre. No vote logic is instantiated.

Decomposition:
- Package uart_pkg:
  - state_t enum (IDLE, START, DATA, PARITY, STOP, BREAK)
  - parity_t encoding (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2)
  - a parity-compute function
- One sub-module, uart_os_tick_gen: runtime-divisor tick generator with async active-high reset and a restart input. The rest of the block is FSM plus output register.

Test Plan:
- 8N1, OVERSAMPLE=16, i_div=0, i_ready=1. Send 0xA5 -> o_valid one cycle after the stop centre, o_data=0xA5, both error flags 0, o_overrun never pulses.
- PARITY=2 (even). Send 0x0F with parity bit 1 -> o_parity_err=1, o_data=0x0F. Send with correct parity 0 -> o_parity_err=0.
- Glitch: 4-clock low pulse on i_rx at i_div=0 -> FSM returns to IDLE, o_valid stays 0. Then a 20-bit-time low break -> one word with o_data=0, o_frame_err=1, FSM in BREAK until the line goes high, then IDLE.
- Handshake: i_ready=0, send 0x11 then 0x22 back-to-back -> o_data holds 0x11, o_overrun pulses once at 0x22's completion. Raise i_ready -> o_valid drops.
- Simultaneous: assert i_ready exactly on the cycle 0x33 completes while 0x11 is held -> 0x11 accepted, o_data=0x33, o_valid=1, no overrun.
- Async reset mid-DATA, then i_div changed to 4 -> all outputs reset immediately. Frame 0x5A at 80 clk/bit is then received correctly; with UART_RX_MAJORITY_EN, a 1-tick glitch at a bit centre does not corrupt the data.
